// File: rtl/bytebeat_voice_bank.sv
// bytebeat_voice_bank
//   Multi-channel bytebeat engine. A prescaler produces a one-cycle sample
//   strobe (tick) every DIV clocks; each enabled channel advances its time
//   counter t on the tick edge (E), evaluates one of four formulas at E+1,
//   and the averaged mix of all channel samples is loaded at E+2.
//   Every channel also drives a PWM pin from its current sample.
//
// Optional build macro: BYTEBEAT_SYNC_EN adds the 'sync' input, which
//   zeroes the prescaler and all time counters on the next edge.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   sync              (BYTEBEAT_SYNC_EN only) restart prescaler and t
//   a, b, c, d        shared 4-bit knobs
//   mode              2 bits per channel formula select
//   ch_en             per-channel enable
//   mix_out/mix_vld   averaged mix stream, mix_rdy from the consumer
//   overrun, ovf_clr  sticky overwrite flag and its clear
//   pwm_out           per-channel PWM audio
//
// Stream handshake (mix_out / mix_vld / mix_rdy):
//   A transfer happens on any edge with mix_vld=1 and mix_rdy=1. mix_vld then
//   drops unless a new mix loads on that same edge. While mix_vld=1 and
//   mix_rdy=0, mix_out holds, except that a new mix still overwrites it and
//   raises overrun. overrun stays set until ovf_clr; a set on the same edge
//   as a clear wins.
module bytebeat_voice_bank #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 8,
  parameter int T_W      = 16,
  parameter int DIV      = 512
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef BYTEBEAT_SYNC_EN
  input  logic                  sync,
`endif
  input  logic [3:0]            a,
  input  logic [3:0]            b,
  input  logic [3:0]            c,
  input  logic [3:0]            d,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [NUM_CH-1:0]     ch_en,
  output logic [SAMPLE_W-1:0]   mix_out,
  output logic                  mix_vld,
  input  logic                  mix_rdy,
  output logic                  overrun,
  input  logic                  ovf_clr,
  output logic [NUM_CH-1:0]     pwm_out
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PS_W  = $clog2(DIV);
  localparam int SUM_W = SAMPLE_W + CH_W;

  logic [PS_W-1:0]     presc;
  logic                tick;
  logic                tick_q1;   // high during the cycle before edge E+1
  logic                tick_q2;   // high during the cycle before edge E+2
  logic                sync_i;
  logic [T_W-1:0]      t      [NUM_CH];
  logic [SAMPLE_W-1:0] f_val  [NUM_CH];
  logic [SAMPLE_W-1:0] sample [NUM_CH];
  logic [SAMPLE_W-1:0] cmp    [NUM_CH];
  logic [SAMPLE_W-1:0] cnt;
  logic [SUM_W-1:0]    sum;
  logic [SAMPLE_W-1:0] mix_next;
  logic                unused_knobs;

`ifdef BYTEBEAT_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  // c[3] and d[3:2] do not feed any formula.
  assign unused_knobs = &{1'b0, c[3], d[3:2]};

  assign tick = (presc == PS_W'(DIV - 1));

  // Only the low SAMPLE_W bits of each formula are kept, and those bits of
  // a product depend only on the low bits of its operands, so computing the
  // products at T_W bits gives the same result as the full-width product.
  function automatic logic [SAMPLE_W-1:0] eval_formula(
    input logic [1:0]     m,
    input logic [T_W-1:0] tv,
    input logic [3:0]     ka,
    input logic [3:0]     kb,
    input logic [2:0]     kc,
    input logic [1:0]     kd
  );
    logic [T_W-1:0] mul_a;
    logic [T_W-1:0] mul_b;
    mul_a = tv * T_W'({1'b0, ka} + 5'd1);
    mul_b = tv * T_W'({1'b0, kb} + 5'd1);
    case (m)
      2'd0:    return SAMPLE_W'(mul_a & (tv >> ({2'b0, kb[1:0]} + 4'd5)));
      2'd1:    return SAMPLE_W'(tv ^ (tv >> ({1'b0, kc} + 4'd1)));
      2'd2:    return SAMPLE_W'((tv >> ({2'b0, kd} + 4'd3)) | mul_b);
      default: return SAMPLE_W'(tv & (tv >> 8));
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      f_val[i] = eval_formula(mode[2*i +: 2], t[i], a, b, c[2:0], d[1:0]);
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sum + SUM_W'(sample[i]);
    end
    mix_next = SAMPLE_W'(sum >> CH_W);
  end

  // Prescaler, time counters and the tick pipeline. sync overrides tick and
  // also cancels the pending sample/mix strobes of a coinciding tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      tick_q1 <= 1'b0;
      tick_q2 <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) t[i] <= '0;
    end else begin
      tick_q1 <= tick & ~sync_i;
      tick_q2 <= tick_q1;
      if (sync_i || tick) presc <= '0;
      else                presc <= presc + PS_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_i)                t[i] <= '0;
        else if (tick && ch_en[i]) t[i] <= t[i] + T_W'(1);
      end
    end
  end

  // Sample registers: knobs and mode are only looked at on this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) sample[i] <= '0;
    end else if (tick_q1) begin
      for (int i = 0; i < NUM_CH; i++) sample[i] <= ch_en[i] ? f_val[i] : '0;
    end
  end

  // Mix output register and stream handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      mix_out <= '0;
      mix_vld <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (tick_q2) begin
        mix_out <= mix_next;
        mix_vld <= 1'b1;
      end else if (mix_vld && mix_rdy) begin
        mix_vld <= 1'b0;
      end
      if (tick_q2 && mix_vld && !mix_rdy) overrun <= 1'b1;
      else if (ovf_clr)                   overrun <= 1'b0;
    end
  end

  // PWM: compares reload only while the counter sits at its maximum, so a
  // new duty starts cleanly with the next period.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pwm_out <= '0;
      for (int i = 0; i < NUM_CH; i++) cmp[i] <= '0;
    end else begin
      cnt <= cnt + SAMPLE_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt == '1) cmp[i] <= sample[i];
        pwm_out[i] <= (cnt < cmp[i]);
      end
    end
  end

endmodule
